// File: rtl/grid_bus_serializer_pkg.sv
// Shared types and sizing for the grid result-bus serializer.
// Default widths, per-word byte count and FSM state encoding.
package grid_pkg;

  localparam int GRID_WORD_W = 32;
  localparam int GRID_BYTE_W = 8;
  localparam int BYTES_PER_WORD = GRID_WORD_W / GRID_BYTE_W;
  localparam int IDX_W = (BYTES_PER_WORD > 1) ?
                         $clog2(BYTES_PER_WORD) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/grid_bus_serializer_if.sv
// Word-in / byte-out handshake bundle of the serializer.
// master drives words and byte_ready; slave is the serializer.
interface grid_bus_serializer_if
  import grid_pkg::*;
#(
  parameter int WORD_W = GRID_WORD_W,
  parameter int BYTE_W = GRID_BYTE_W
);

  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic [BYTE_W-1:0] byte_out;
  logic              byte_valid;
  logic              byte_ready;
  logic              byte_last;

  modport master (
    output word_in,
    output word_valid,
    input  word_ready,
    input  byte_out,
    input  byte_valid,
    output byte_ready,
    input  byte_last
  );

  modport slave (
    input  word_in,
    input  word_valid,
    output word_ready,
    output byte_out,
    output byte_valid,
    input  byte_ready,
    output byte_last
  );

endinterface

// File: rtl/grid_bus_serializer_word_slot.sv
// One-word holding slot behind the shifter.
// Accepts a word while empty; drains into the shifter on demand.
module grid_word_slot
  import grid_pkg::*;
#(
  parameter int W = GRID_WORD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_word,
  input  logic         drain,
  output logic [W-1:0] slot_word,
  output logic         slot_valid,
  output logic         word_ready
);

  assign word_ready = !slot_valid;

  // Valid flag: load only happens when empty, drain only when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= 1'b0;
    end else if (load) begin
      slot_valid <= 1'b1;
    end else if (drain) begin
      slot_valid <= 1'b0;
    end
  end

  // Data register captures the word on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_word <= '0;
    end else if (load) begin
      slot_word <= load_word;
    end
  end

endmodule

// File: rtl/grid_bus_serializer.sv
// Streams 32-bit result-bus words out as bytes with a holding slot.
// Keeps a running XOR signature of every byte handed off.
module grid_bus_serializer
  import grid_pkg::*;
#(
  parameter int WORD_W    = GRID_WORD_W,
  parameter int BYTE_W    = GRID_BYTE_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  grid_bus_serializer_if.slave bus,
  input  logic              sig_clr,
  output logic [BYTE_W-1:0] sig_out,
  output logic              busy
);

  localparam int NB = WORD_W / BYTE_W;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);

  state_e            state;
  logic              shf_valid;
  logic [WORD_W-1:0] shf;
  logic [IW-1:0]     idx;
  logic [BYTE_W-1:0] sig;
  logic [BYTE_W-1:0] sel;

  logic [WORD_W-1:0] slot_word;
  logic              slot_valid;
  logic              word_ready;

  logic byte_hs;
  logic word_acc;
  logic end_hs;
  logic slot_load;
  logic slot_drain;

  assign shf_valid  = (state == ST_SEND);
  assign byte_hs    = shf_valid && bus.byte_ready;
  assign word_acc   = bus.word_valid && word_ready;
  assign end_hs     = byte_hs && (idx == IDX_LAST);
  // A word arriving on the last-byte edge with an empty slot
  // bypasses the slot and goes straight into the shifter.
  assign slot_load  = word_acc && shf_valid && !end_hs;
  assign slot_drain = end_hs && slot_valid;

  grid_word_slot #(
    .W (WORD_W)
  ) u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (slot_load),
    .load_word  (bus.word_in),
    .drain      (slot_drain),
    .slot_word  (slot_word),
    .slot_valid (slot_valid),
    .word_ready (word_ready)
  );

  // Pick the current byte lane; zero while idle.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NB; i++) begin
      if (shf_valid && idx == IW'(i)) begin
        sel = shf[(MSB_FIRST ? NB - 1 - i : i) * BYTE_W +: BYTE_W];
      end
    end
  end

  // FSM, shifter and byte index with slot-first refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      shf   <= '0;
      idx   <= '0;
    end else if (!shf_valid) begin
      if (word_acc) begin
        state <= ST_SEND;
        shf   <= bus.word_in;
        idx   <= '0;
      end
    end else if (byte_hs) begin
      if (idx != IDX_LAST) begin
        idx <= idx + IW'(1);
      end else if (slot_valid) begin
        shf <= slot_word;
        idx <= '0;
      end else if (word_acc) begin
        shf <= bus.word_in;
        idx <= '0;
      end else begin
        state <= ST_IDLE;
        idx   <= '0;
      end
    end
  end

  // Signature: clear takes effect before the same-cycle byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (sig_clr) begin
      sig <= byte_hs ? sel : '0;
    end else if (byte_hs) begin
      sig <= sig ^ sel;
    end
  end

  assign bus.word_ready = word_ready;
  assign bus.byte_out   = sel;
  assign bus.byte_valid = shf_valid;
  assign bus.byte_last  = shf_valid && (idx == IDX_LAST);
  assign sig_out        = sig;
  assign busy           = shf_valid | slot_valid;

endmodule

// File: tb/tb_grid_bus_serializer.sv
// Self-checking bench for grid_bus_serializer.
// Byte-queue reference model checked every cycle plus directed checks.
module tb_grid_bus_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sig_clr = 1'b0;
  logic [7:0] sig_out;
  logic       busy;

  int n_chk = 0;
  int n_fail = 0;

  grid_bus_serializer_if #(.WORD_W(32), .BYTE_W(8)) bus ();

  grid_bus_serializer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .sig_clr (sig_clr),
    .sig_out (sig_out),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Reference model: every byte still owed, in emission order.
  logic [7:0] q[$];
  logic [7:0] sig_m = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pend_words();
    return (q.size() + 3) / 4;
  endfunction

  task automatic check_outputs();
    logic ev;
    ev = (q.size() != 0);
    chk("byte_valid", 32'(bus.byte_valid), 32'(ev));
    chk("byte_out", 32'(bus.byte_out), ev ? 32'(q[0]) : 32'h0);
    chk("byte_last", 32'(bus.byte_last),
        32'(ev && (q.size() % 4 == 1)));
    chk("word_ready", 32'(bus.word_ready), 32'(pend_words() < 2));
    chk("busy", 32'(busy), 32'(ev));
    chk("sig_out", 32'(sig_out), 32'(sig_m));
  endtask

  // One clock: drive at negedge, check, advance the model.
  task automatic cyc(input logic wv, input logic [31:0] w,
                     input logic br, input logic clr,
                     output logic acc);
    logic hs;
    logic [7:0] b;
    bus.word_valid = wv;
    bus.word_in    = w;
    bus.byte_ready = br;
    sig_clr        = clr;
    #1;
    check_outputs();
    hs  = (q.size() != 0) && br;
    acc = wv && (pend_words() < 2);
    b   = 8'h00;
    if (hs) b = q.pop_front();
    if (clr) sig_m = hs ? b : 8'h00;
    else if (hs) sig_m = sig_m ^ b;
    if (acc) begin
      for (int i = 3; i >= 0; i--) q.push_back(w[i*8 +: 8]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic br);
    logic a;
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, br, 1'b0, a);
  endtask

  // Offer a word until taken, bounded.
  task automatic push_word(input logic [31:0] w, input logic br);
    logic a;
    int k;
    a = 1'b0;
    k = 0;
    while (!a && k < 40) begin
      cyc(1'b1, w, br, 1'b0, a);
      k++;
    end
    chk("push_word_taken", 32'(a), 32'h1);
  endtask

  initial begin
    logic a;
    bus.word_valid = 1'b0;
    bus.word_in    = '0;
    bus.byte_ready = 1'b1;

    // Reset
    repeat (3) @(negedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs();

    // Single word DEADBEEF
    push_word(32'hDEADBEEF, 1'b1);
    chk("dead_b0", 32'(bus.byte_out), 32'hDE);
    idle(6, 1'b1);
    chk("dead_sig", 32'(sig_out), 32'h22);

    // Back-to-back, signature cleared first
    cyc(1'b1, 32'h01020304, 1'b1, 1'b1, a);
    cyc(1'b1, 32'h05060708, 1'b1, 1'b0, a);
    chk("b2b_slot_ready", 32'(bus.word_ready), 32'h0);
    idle(9, 1'b1);
    chk("b2b_sig", 32'(sig_out), 32'h08);

    // Backpressure on second byte
    push_word(32'hA1B2C3D4, 1'b1);
    idle(1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      idle(1, 1'b0);
      chk("stall_byte", 32'(bus.byte_out), 32'hB2);
    end
    idle(5, 1'b1);

    // Slot full: third word waits for the slot to drain
    push_word(32'hCAFEF00D, 1'b1);
    push_word(32'h12345678, 1'b1);
    cyc(1'b1, 32'h11223344, 1'b0, 1'b0, a);
    chk("full_not_taken", 32'(a), 32'h0);
    push_word(32'h11223344, 1'b1);
    idle(14, 1'b1);

    // Direct refill on the last-byte edge with an empty slot
    push_word(32'h0F1E2D3C, 1'b1);
    idle(3, 1'b1);
    push_word(32'h4B5A6978, 1'b1);
    idle(6, 1'b1);

    // sig_clr coincident with the 0x5A handshake
    push_word(32'h5A123456, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, a);
    chk("clr_sig", 32'(sig_out), 32'h5A);
    idle(4, 1'b1);

    // Asynchronous reset during byte 2
    push_word(32'h99887766, 1'b1);
    push_word(32'h55443322, 1'b1);
    idle(1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    sig_m = 8'h00;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    idle(6, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom,
          1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 15) == 0), a);
    end
    idle(20, 1'b1);
    chk("drained", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
